instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU's `PC`/`INSTRUCTION` port and the block-wide instruction memory. It is the responder for the CPU's fetch: it takes the PC as a fetch address and returns the 32-bit instruction. A hit completes with no stall. A miss raises `BUSYWAIT` to freeze the PC, fetches a 16-byte block from memory, and refills the line. The CPU holds `PC` and skips its PC update while `BUSYWAIT`=1.

---
 rtl/instruction_cache.sv | 139 +++++++++++++
 tb/tb_instruction_cache.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, 16-byte block refill on miss.
// Optional hit/miss statistics counters enabled by defining ICACHE_STATS_EN.
module instruction_cache #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic              READ,
    output logic [31:0]       READDATA,
    output logic              BUSYWAIT,
    output logic [ADDR_W-5:0] MEM_ADDRESS,
    output logic              MEM_READ,
    input  logic [127:0]      MEM_READDATA,
    input  logic              MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       HIT_COUNT,
    output logic [15:0]       MISS_COUNT
`endif
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 4;
    localparam int unsigned BLK_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FILL
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tags [LINES];
    logic [127:0]          data [LINES];
    logic [BLK_W-1:0]      miss_blk;
    logic [127:0]          fill_buf;

    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_BITS-1:0] addr_idx;
    logic [1:0]            word_sel;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit_c;
    logic                  addr_unused;

    assign addr_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
    assign addr_idx    = ADDRESS[INDEX_BITS+3:4];
    assign word_sel    = ADDRESS[3:2];
    assign addr_unused = ^ADDRESS[1:0];

    assign fill_idx    = miss_blk[INDEX_BITS-1:0];
    assign fill_tag    = miss_blk[BLK_W-1:INDEX_BITS];

    // valid gates the compare so uninitialised tags never reach the FSM
    assign hit_c       = READ & valid[addr_idx] & (tags[addr_idx] == addr_tag);
    assign READDATA    = data[addr_idx][{word_sel, 5'd0} +: 32];
    assign MEM_ADDRESS = miss_blk;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        BUSYWAIT = 1'b0;
        MEM_READ = 1'b0;
        case (state)
            S_IDLE: begin
                if (READ && !hit_c) begin
                    BUSYWAIT = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_nx = S_FILL;
                end
            end
            S_FILL: begin
                BUSYWAIT = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Miss address is latched once so ADDRESS may wander during the refill
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid    <= '0;
            miss_blk <= '0;
        end else begin
            if (state == S_IDLE && state_nx == S_FETCH) begin
                miss_blk <= ADDRESS[ADDR_W-1:4];
            end
            if (state == S_FILL) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; an aborted fill leaves valid clear
    always_ff @(posedge CLK) begin
        if (state == S_FETCH && !MEM_BUSYWAIT) begin
            fill_buf <= MEM_READDATA;
        end
        if (state == S_FILL) begin
            data[fill_idx] <= fill_buf;
            tags[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (state == S_IDLE && hit_c && HIT_COUNT != 16'hFFFF) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (state == S_IDLE && state_nx == S_FETCH && MISS_COUNT != 16'hFFFF) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: driver queues expected fetch results, monitor checks them.
module tb_instruction_cache;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned INDEX_BITS = 3;

    logic              CLK          = 1'b0;
    logic              RESET        = 1'b0;
    logic [ADDR_W-1:0] ADDRESS      = '0;
    logic              READ         = 1'b0;
    logic [31:0]       READDATA;
    logic              BUSYWAIT;
    logic [ADDR_W-5:0] MEM_ADDRESS;
    logic              MEM_READ;
    logic [127:0]      MEM_READDATA = '0;
    logic              MEM_BUSYWAIT = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0]       HIT_COUNT;
    logic [15:0]       MISS_COUNT;
`endif

    instruction_cache #(.ADDR_W(ADDR_W), .INDEX_BITS(INDEX_BITS)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .READ         (READ),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READ     (MEM_READ),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          stall;
        int          mrd;
        logic [7:0]  maddr;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   mem_lat = 0;
    int   mem_cnt = 0;

    // Memory image: word w of block b is {b, 16'(w*0x11)}; block 0 = {0x33,0x22,0x11,0x00}
    function automatic logic [31:0] exp_word(input logic [9:0] a);
        return (32'(a[9:4]) << 16) | (32'(a[3:2]) * 32'h11);
    endfunction

    function automatic logic [127:0] blk_data(input logic [5:0] b);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) begin
            r[w*32 +: 32] = (32'(b) << 16) | (32'(w) * 32'h11);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic finish_sim();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    endtask

    // Memory: busy for mem_lat cycles of MEM_READ, then valid; garbage whenever not asked
    always @(negedge CLK) begin
        if (MEM_READ) begin
            MEM_BUSYWAIT = (mem_cnt < mem_lat);
            MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEADBEEF}} : blk_data(MEM_ADDRESS);
            mem_cnt++;
        end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b0;
            MEM_READDATA = {4{32'hBADC0DE5}};
        end
    end

    // Monitor: accumulates stall/refill activity, checks on each delivered instruction
    int         stall_cnt  = 0;
    int         mrd_cnt    = 0;
    logic [7:0] maddr_seen = 8'hEE;

    always @(negedge CLK) begin
        if (!READ) begin
            stall_cnt  = 0;
            mrd_cnt    = 0;
            maddr_seen = 8'hEE;
        end else if (BUSYWAIT) begin
            stall_cnt++;
            if (MEM_READ) begin
                mrd_cnt++;
                if (maddr_seen == 8'hEE) maddr_seen = 8'(MEM_ADDRESS);
                else if (maddr_seen != 8'(MEM_ADDRESS)) maddr_seen = 8'hFF;
            end
        end else begin
            if (MEM_READ) mrd_cnt++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: READDATA 0x%0h with empty scoreboard", READDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("readdata",    READDATA,         e.data);
                check("stall_cycles", 32'(stall_cnt),  32'(e.stall));
                check("mem_read_cycles", 32'(mrd_cnt), 32'(e.mrd));
                check("mem_address", 32'(maddr_seen),  32'(e.maddr));
            end
            stall_cnt  = 0;
            mrd_cnt    = 0;
            maddr_seen = 8'hEE;
        end
    end

    // Driver: issue one fetch, optionally wander ADDRESS to alt during the refill
    task automatic fetch(input logic [9:0] a, input int lat, input bit miss,
                         input bit use_alt, input logic [9:0] alt);
        exp_t e;
        bit   done;
        mem_lat = lat;
        ADDRESS = a;
        READ    = 1'b1;
        e.data  = exp_word(a);
        e.stall = miss ? lat + 3 : 0;
        e.mrd   = miss ? lat + 1 : 0;
        e.maddr = miss ? 8'(a[9:4]) : 8'hEE;
        sb.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge CLK);
            done = !BUSYWAIT;
            @(posedge CLK);
            #1;
            if (use_alt && k == 1) ADDRESS = alt;
            if (use_alt && k == 2) ADDRESS = a;
        end
        if (!done) begin
            checks++;
            $display("FAIL fetch_timeout: addr 0x%0h still stalled, required completion", a);
            finish_sim();
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_busywait",    32'(BUSYWAIT),    32'd0);
        check("reset_mem_read",    32'(MEM_READ),    32'd0);
        check("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
`ifdef ICACHE_STATS_EN
        check("reset_hit_count",  32'(HIT_COUNT),  32'd0);
        check("reset_miss_count", 32'(MISS_COUNT), 32'd0);
`endif
        @(posedge CLK);
        #1 RESET = 1'b1;

        fetch(10'h000, 4, 1'b1, 1'b0, 10'h0);
        fetch(10'h004, 0, 1'b0, 1'b0, 10'h0);
        fetch(10'h008, 0, 1'b0, 1'b0, 10'h0);
        fetch(10'h00C, 0, 1'b0, 1'b0, 10'h0);
        fetch(10'h080, 2, 1'b1, 1'b0, 10'h0);
`ifdef ICACHE_STATS_EN
        check("stats_miss_count", 32'(MISS_COUNT), 32'd2);
        check("stats_hit_count",  32'(HIT_COUNT),  32'd5);
`endif
        fetch(10'h000, 0, 1'b1, 1'b0, 10'h0);
        fetch(10'h00C, 0, 1'b0, 1'b0, 10'h0);

        // ADDRESS wanders during FETCH; the original line is the one filled
        fetch(10'h114, 3, 1'b1, 1'b1, 10'h3F0);
        fetch(10'h3F0, 1, 1'b1, 1'b0, 10'h0);
        fetch(10'h3FC, 0, 1'b0, 1'b0, 10'h0);
        fetch(10'h114, 0, 1'b0, 1'b0, 10'h0);

        // Reset in the middle of a refill, then a late memory answer
        mem_lat = 5;
        ADDRESS = 10'h050;
        READ    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        READ  = 1'b0;
        RESET = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("abort_mem_read", 32'(MEM_READ), 32'd0);
            check("abort_busywait", 32'(BUSYWAIT), 32'd0);
        end
        @(posedge CLK);
        #1;
        fetch(10'h050, 1, 1'b1, 1'b0, 10'h0);
        fetch(10'h000, 0, 1'b1, 1'b0, 10'h0);
        READ = 1'b0;

        @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        finish_sim();
    end

endmodule
